// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Execute-stage output register sitting directly after alu_64. Each accepted
//   ALU result (result, destination index, status flags) is stored in a
//   2-entry skid buffer (head + skid) and presented to writeback through a
//   valid/ready handshake. The raw overflow flag is masked so it only counts
//   for SUM and SUB. A sticky overflow bit and a saturating overflow event
//   counter are kept.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
//   both high at that edge; a producer holding valid keeps its data stable
//   until the transfer. in_ready is a pure function of the state register.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         upstream handshake
//   in_funct, in_rd             ALU op code and destination register index
//   alu_result, alu_*           ALU result and raw status flags
//   out_valid / out_ready       downstream handshake
//   out_result, out_rd          head entry result and destination index
//   out_flags                   {ovf_masked, negative, zero, equal, greater, less}
//   ovf_sticky, ovf_count       overflow history, cleared by ovf_clear
//   dbg_state                   current buffer state (EMPTY=0, ONE=1, FULL=2)
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_equal,
    input  logic              alu_greater,
    input  logic              alu_less,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic [5:0]        out_flags,
    output logic              ovf_sticky,
    input  logic              ovf_clear,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [1:0]        dbg_state
);

    localparam int ENTRY_W = DATA_W + RD_W + 6;

    localparam logic [2:0] FUNCT_SUM = 3'd0;
    localparam logic [2:0] FUNCT_SUB = 3'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   head_q, head_d;
    logic [ENTRY_W-1:0]   skid_q, skid_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 push;
    logic                 pop;
    logic                 ovf_masked;
    logic                 ovf_event;
    logic [ENTRY_W-1:0]   in_entry;

    // Overflow is only meaningful for signed add/subtract.
    assign ovf_masked = alu_overflow & ((in_funct == FUNCT_SUM) | (in_funct == FUNCT_SUB));
    assign in_entry   = {alu_result, in_rd, ovf_masked, alu_negative, alu_zero,
                         alu_equal, alu_greater, alu_less};

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign ovf_event = push & ovf_masked;

    // Outputs come straight from the head register; skid never reaches them.
    assign out_result = head_q[ENTRY_W-1 -: DATA_W];
    assign out_rd     = head_q[5+RD_W -: RD_W];
    assign out_flags  = head_q[5:0];
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;
    assign dbg_state  = state_q;

    // Buffer next-state logic.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    skid_d  = in_entry;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Overflow history: a new event in the clearing cycle survives the clear.
    always_comb begin
        sticky_d = (sticky_q & ~ovf_clear) | ovf_event;
        count_d  = count_q;
        if (ovf_clear) begin
            count_d = ovf_event ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (ovf_event && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

endmodule
